galileo_block_interleaver: RTL

- Sits directly downstream of the K=7 rate-1/2 convolutional encoder.
- Consumes its encoded symbol pairs (dv + 2-bit symbol).
- Performs the Galileo-style row/column block interleave over one frame of ROWS*COLS symbols.
- Emits one interleaved symbol per cycle with frame markers. Ping-pong buffering lets one frame fill while the previous one drains.

---
 rtl/galileo_block_interleaver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/galileo_block_interleaver.sv
// Ping-pong row/column block interleaver for rate-1/2 encoded symbol pairs.
// Symbols are written row-major into one bank while the other bank is read column-major.
module galileo_block_interleaver #(
  parameter int ROWS = 8,
  parameter int COLS = 30,
  parameter int AW   = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sync_in,
  input  logic       dv_in,
  input  logic [1:0] din,
  output logic       dv_out,
  output logic       dout,
  output logic       sof,
  output logic       eof,
  output logic       overrun
);
  localparam int N = ROWS * COLS;
  localparam logic [AW-1:0] LAST_PAIR = AW'(N - 2);
  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_COL  = AW'(COLS - 1);
  localparam logic [AW-1:0] COL_STEP  = AW'(COLS);

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_st_t;

  bank_st_t        st_r [2];
  bank_st_t        st_nxt_s [2];
  bank_st_t        rd_st_s [2];
  logic [2**AW-1:0] mem_r [2];
  logic [AW-1:0]   w_r, widx_s, widx_p1_s, w_nxt_s;
  logic [AW-1:0]   row_r, col_r, addr_r;
  logic [AW-1:0]   cur_row_s, cur_col_s, cur_addr_s;
  logic            wb_r, rb_r, rd_active_r;
  logic            start_s, issue_s, last_s;
  logic            avail_s, wr_en_s, fill_done_s;
  logic            dv_out_r, dout_r, sof_r, eof_r, overrun_r;

  // Reader issue: start the next bank in fill order once FULL, else keep walking.
  always_comb begin
    start_s = !rd_active_r && (st_r[rb_r] == BANK_FULL);
    issue_s = rd_active_r || start_s;
    if (rd_active_r) begin
      cur_row_s  = row_r;
      cur_col_s  = col_r;
      cur_addr_s = addr_r;
    end else begin
      cur_row_s  = '0;
      cur_col_s  = '0;
      cur_addr_s = '0;
    end
    last_s = issue_s && (cur_row_s == LAST_ROW) && (cur_col_s == LAST_COL);
  end

  // Writer: a bank being released on this very cycle accepts the incoming pair.
  always_comb begin
    if (sync_in) begin
      widx_s = '0;
    end else begin
      widx_s = w_r;
    end
    widx_p1_s   = widx_s + AW'(1);
    avail_s     = (st_r[wb_r] == BANK_FREE) || (st_r[wb_r] == BANK_FILLING) ||
                  (last_s && (rb_r == wb_r));
    wr_en_s     = dv_in && avail_s;
    fill_done_s = wr_en_s && (widx_s == LAST_PAIR);
    if (fill_done_s) begin
      w_nxt_s = '0;
    end else if (wr_en_s) begin
      w_nxt_s = widx_s + AW'(2);
    end else begin
      w_nxt_s = widx_s;
    end
  end

  // Per-bank state: read-side transitions first, write side may then claim the bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      rd_st_s[b]  = st_r[b];
      st_nxt_s[b] = st_r[b];
      if (last_s && (rb_r == 1'(b))) begin
        rd_st_s[b] = BANK_FREE;
      end else if (start_s && (rb_r == 1'(b))) begin
        rd_st_s[b] = BANK_READING;
      end else begin
        rd_st_s[b] = st_r[b];
      end
      if (wr_en_s && (wb_r == 1'(b))) begin
        st_nxt_s[b] = fill_done_s ? BANK_FULL : BANK_FILLING;
      end else if (sync_in && (wb_r == 1'(b)) && (st_r[b] == BANK_FILLING)) begin
        st_nxt_s[b] = BANK_FREE;
      end else begin
        st_nxt_s[b] = rd_st_s[b];
      end
    end
  end

  // Control state, read address counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_r[0]     <= BANK_FREE;
      st_r[1]     <= BANK_FREE;
      w_r         <= '0;
      wb_r        <= 1'b0;
      rb_r        <= 1'b0;
      rd_active_r <= 1'b0;
      row_r       <= '0;
      col_r       <= '0;
      addr_r      <= '0;
      dv_out_r    <= 1'b0;
      dout_r      <= 1'b0;
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      st_r[0] <= st_nxt_s[0];
      st_r[1] <= st_nxt_s[1];
      w_r     <= w_nxt_s;
      if (fill_done_s) begin
        wb_r <= ~wb_r;
      end
      if (dv_in && !avail_s) begin
        overrun_r <= 1'b1;
      end
      // Address walks down a column by COLS, then restarts at the next column.
      if (last_s) begin
        rd_active_r <= 1'b0;
        rb_r        <= ~rb_r;
        row_r       <= '0;
        col_r       <= '0;
        addr_r      <= '0;
      end else if (issue_s) begin
        rd_active_r <= 1'b1;
        if (cur_row_s == LAST_ROW) begin
          row_r  <= '0;
          col_r  <= cur_col_s + AW'(1);
          addr_r <= cur_col_s + AW'(1);
        end else begin
          row_r  <= cur_row_s + AW'(1);
          col_r  <= cur_col_s;
          addr_r <= cur_addr_s + COL_STEP;
        end
      end
      dv_out_r <= issue_s;
      sof_r    <= start_s;
      eof_r    <= last_s;
      dout_r   <= issue_s ? mem_r[rb_r][cur_addr_s] : 1'b0;
    end
  end

  // Bank storage: never cleared, a bank is only read after a complete fill.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wb_r][widx_s]    <= din[0];
      mem_r[wb_r][widx_p1_s] <= din[1];
    end
  end

  assign dv_out  = dv_out_r;
  assign dout    = dout_r;
  assign sof     = sof_r;
  assign eof     = eof_r;
  assign overrun = overrun_r;

endmodule
